// File: rtl/aes_pkg.sv
// Shared types, FSM encoding and GF(2^8) helpers for the forward AES-128 core.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_fsm_t;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_byte_t gmul2(input aes_byte_t b);
        return xtime(b);
    endfunction

    function automatic aes_byte_t gmul3(input aes_byte_t b);
        return xtime(b) ^ b;
    endfunction

    // Row n rotates left by n byte positions; byte i sits at row i%4, column i/4.
    function automatic aes_block_t shift_rows(input aes_block_t s);
        aes_block_t o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    // Column-wise multiply by the fixed [2 3 1 1] circulant matrix.
    function automatic aes_block_t mix_columns(input aes_block_t s);
        aes_block_t o;
        aes_byte_t  a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3);
            o[103 - 32*c -: 8] = gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox_fwd.sv
// Combinational forward AES S-box as a 256-entry case ROM.
module aes_sbox_fwd
    import aes_pkg::*;
(
    input  aes_byte_t value,
    output aes_byte_t result
);

    // Table lookup of SubBytes for one byte.
    always_comb begin
        result = 8'h00;
        case (value)
            8'h00: result = 8'h63; 8'h01: result = 8'h7c; 8'h02: result = 8'h77; 8'h03: result = 8'h7b;
            8'h04: result = 8'hf2; 8'h05: result = 8'h6b; 8'h06: result = 8'h6f; 8'h07: result = 8'hc5;
            8'h08: result = 8'h30; 8'h09: result = 8'h01; 8'h0a: result = 8'h67; 8'h0b: result = 8'h2b;
            8'h0c: result = 8'hfe; 8'h0d: result = 8'hd7; 8'h0e: result = 8'hab; 8'h0f: result = 8'h76;
            8'h10: result = 8'hca; 8'h11: result = 8'h82; 8'h12: result = 8'hc9; 8'h13: result = 8'h7d;
            8'h14: result = 8'hfa; 8'h15: result = 8'h59; 8'h16: result = 8'h47; 8'h17: result = 8'hf0;
            8'h18: result = 8'had; 8'h19: result = 8'hd4; 8'h1a: result = 8'ha2; 8'h1b: result = 8'haf;
            8'h1c: result = 8'h9c; 8'h1d: result = 8'ha4; 8'h1e: result = 8'h72; 8'h1f: result = 8'hc0;
            8'h20: result = 8'hb7; 8'h21: result = 8'hfd; 8'h22: result = 8'h93; 8'h23: result = 8'h26;
            8'h24: result = 8'h36; 8'h25: result = 8'h3f; 8'h26: result = 8'hf7; 8'h27: result = 8'hcc;
            8'h28: result = 8'h34; 8'h29: result = 8'ha5; 8'h2a: result = 8'he5; 8'h2b: result = 8'hf1;
            8'h2c: result = 8'h71; 8'h2d: result = 8'hd8; 8'h2e: result = 8'h31; 8'h2f: result = 8'h15;
            8'h30: result = 8'h04; 8'h31: result = 8'hc7; 8'h32: result = 8'h23; 8'h33: result = 8'hc3;
            8'h34: result = 8'h18; 8'h35: result = 8'h96; 8'h36: result = 8'h05; 8'h37: result = 8'h9a;
            8'h38: result = 8'h07; 8'h39: result = 8'h12; 8'h3a: result = 8'h80; 8'h3b: result = 8'he2;
            8'h3c: result = 8'heb; 8'h3d: result = 8'h27; 8'h3e: result = 8'hb2; 8'h3f: result = 8'h75;
            8'h40: result = 8'h09; 8'h41: result = 8'h83; 8'h42: result = 8'h2c; 8'h43: result = 8'h1a;
            8'h44: result = 8'h1b; 8'h45: result = 8'h6e; 8'h46: result = 8'h5a; 8'h47: result = 8'ha0;
            8'h48: result = 8'h52; 8'h49: result = 8'h3b; 8'h4a: result = 8'hd6; 8'h4b: result = 8'hb3;
            8'h4c: result = 8'h29; 8'h4d: result = 8'he3; 8'h4e: result = 8'h2f; 8'h4f: result = 8'h84;
            8'h50: result = 8'h53; 8'h51: result = 8'hd1; 8'h52: result = 8'h00; 8'h53: result = 8'hed;
            8'h54: result = 8'h20; 8'h55: result = 8'hfc; 8'h56: result = 8'hb1; 8'h57: result = 8'h5b;
            8'h58: result = 8'h6a; 8'h59: result = 8'hcb; 8'h5a: result = 8'hbe; 8'h5b: result = 8'h39;
            8'h5c: result = 8'h4a; 8'h5d: result = 8'h4c; 8'h5e: result = 8'h58; 8'h5f: result = 8'hcf;
            8'h60: result = 8'hd0; 8'h61: result = 8'hef; 8'h62: result = 8'haa; 8'h63: result = 8'hfb;
            8'h64: result = 8'h43; 8'h65: result = 8'h4d; 8'h66: result = 8'h33; 8'h67: result = 8'h85;
            8'h68: result = 8'h45; 8'h69: result = 8'hf9; 8'h6a: result = 8'h02; 8'h6b: result = 8'h7f;
            8'h6c: result = 8'h50; 8'h6d: result = 8'h3c; 8'h6e: result = 8'h9f; 8'h6f: result = 8'ha8;
            8'h70: result = 8'h51; 8'h71: result = 8'ha3; 8'h72: result = 8'h40; 8'h73: result = 8'h8f;
            8'h74: result = 8'h92; 8'h75: result = 8'h9d; 8'h76: result = 8'h38; 8'h77: result = 8'hf5;
            8'h78: result = 8'hbc; 8'h79: result = 8'hb6; 8'h7a: result = 8'hda; 8'h7b: result = 8'h21;
            8'h7c: result = 8'h10; 8'h7d: result = 8'hff; 8'h7e: result = 8'hf3; 8'h7f: result = 8'hd2;
            8'h80: result = 8'hcd; 8'h81: result = 8'h0c; 8'h82: result = 8'h13; 8'h83: result = 8'hec;
            8'h84: result = 8'h5f; 8'h85: result = 8'h97; 8'h86: result = 8'h44; 8'h87: result = 8'h17;
            8'h88: result = 8'hc4; 8'h89: result = 8'ha7; 8'h8a: result = 8'h7e; 8'h8b: result = 8'h3d;
            8'h8c: result = 8'h64; 8'h8d: result = 8'h5d; 8'h8e: result = 8'h19; 8'h8f: result = 8'h73;
            8'h90: result = 8'h60; 8'h91: result = 8'h81; 8'h92: result = 8'h4f; 8'h93: result = 8'hdc;
            8'h94: result = 8'h22; 8'h95: result = 8'h2a; 8'h96: result = 8'h90; 8'h97: result = 8'h88;
            8'h98: result = 8'h46; 8'h99: result = 8'hee; 8'h9a: result = 8'hb8; 8'h9b: result = 8'h14;
            8'h9c: result = 8'hde; 8'h9d: result = 8'h5e; 8'h9e: result = 8'h0b; 8'h9f: result = 8'hdb;
            8'ha0: result = 8'he0; 8'ha1: result = 8'h32; 8'ha2: result = 8'h3a; 8'ha3: result = 8'h0a;
            8'ha4: result = 8'h49; 8'ha5: result = 8'h06; 8'ha6: result = 8'h24; 8'ha7: result = 8'h5c;
            8'ha8: result = 8'hc2; 8'ha9: result = 8'hd3; 8'haa: result = 8'hac; 8'hab: result = 8'h62;
            8'hac: result = 8'h91; 8'had: result = 8'h95; 8'hae: result = 8'he4; 8'haf: result = 8'h79;
            8'hb0: result = 8'he7; 8'hb1: result = 8'hc8; 8'hb2: result = 8'h37; 8'hb3: result = 8'h6d;
            8'hb4: result = 8'h8d; 8'hb5: result = 8'hd5; 8'hb6: result = 8'h4e; 8'hb7: result = 8'ha9;
            8'hb8: result = 8'h6c; 8'hb9: result = 8'h56; 8'hba: result = 8'hf4; 8'hbb: result = 8'hea;
            8'hbc: result = 8'h65; 8'hbd: result = 8'h7a; 8'hbe: result = 8'hae; 8'hbf: result = 8'h08;
            8'hc0: result = 8'hba; 8'hc1: result = 8'h78; 8'hc2: result = 8'h25; 8'hc3: result = 8'h2e;
            8'hc4: result = 8'h1c; 8'hc5: result = 8'ha6; 8'hc6: result = 8'hb4; 8'hc7: result = 8'hc6;
            8'hc8: result = 8'he8; 8'hc9: result = 8'hdd; 8'hca: result = 8'h74; 8'hcb: result = 8'h1f;
            8'hcc: result = 8'h4b; 8'hcd: result = 8'hbd; 8'hce: result = 8'h8b; 8'hcf: result = 8'h8a;
            8'hd0: result = 8'h70; 8'hd1: result = 8'h3e; 8'hd2: result = 8'hb5; 8'hd3: result = 8'h66;
            8'hd4: result = 8'h48; 8'hd5: result = 8'h03; 8'hd6: result = 8'hf6; 8'hd7: result = 8'h0e;
            8'hd8: result = 8'h61; 8'hd9: result = 8'h35; 8'hda: result = 8'h57; 8'hdb: result = 8'hb9;
            8'hdc: result = 8'h86; 8'hdd: result = 8'hc1; 8'hde: result = 8'h1d; 8'hdf: result = 8'h9e;
            8'he0: result = 8'he1; 8'he1: result = 8'hf8; 8'he2: result = 8'h98; 8'he3: result = 8'h11;
            8'he4: result = 8'h69; 8'he5: result = 8'hd9; 8'he6: result = 8'h8e; 8'he7: result = 8'h94;
            8'he8: result = 8'h9b; 8'he9: result = 8'h1e; 8'hea: result = 8'h87; 8'heb: result = 8'he9;
            8'hec: result = 8'hce; 8'hed: result = 8'h55; 8'hee: result = 8'h28; 8'hef: result = 8'hdf;
            8'hf0: result = 8'h8c; 8'hf1: result = 8'ha1; 8'hf2: result = 8'h89; 8'hf3: result = 8'h0d;
            8'hf4: result = 8'hbf; 8'hf5: result = 8'he6; 8'hf6: result = 8'h42; 8'hf7: result = 8'h68;
            8'hf8: result = 8'h41; 8'hf9: result = 8'h99; 8'hfa: result = 8'h2d; 8'hfb: result = 8'h0f;
            8'hfc: result = 8'hb0; 8'hfd: result = 8'h54; 8'hfe: result = 8'hbb; 8'hff: result = 8'h16;
            default: result = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption: one round per clock, round keys expanded on the fly.
module aes128_encrypt_core
    import aes_pkg::*;
#(
    parameter int unsigned NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    aes_fsm_t   fsm;
    aes_fsm_t   fsm_next;
    aes_block_t state;
    aes_block_t rk;
    logic [3:0] round_cnt;
    aes_byte_t  rcon;

    aes_block_t sub_bytes;
    aes_block_t shifted;
    aes_block_t mixed;
    aes_block_t rk_next;
    aes_block_t round_out;
    aes_word_t  rot_word;
    aes_word_t  sub_word;
    aes_word_t  w0_next;
    aes_word_t  w1_next;
    aes_word_t  w2_next;
    aes_word_t  w3_next;
    logic       accept;
    logic       last_round;

    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox_fwd u_sbox (
            .value  (state[127 - 8*i -: 8]),
            .result (sub_bytes[127 - 8*i -: 8])
        );
    end

    assign rot_word = {rk[23:0], rk[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sub_word
        aes_sbox_fwd u_sbox (
            .value  (rot_word[31 - 8*j -: 8]),
            .result (sub_word[31 - 8*j -: 8])
        );
    end

    // Key-schedule XOR chain and round datapath; the final round bypasses MixColumns.
    always_comb begin
        w0_next    = rk[127:96] ^ sub_word ^ {rcon, 24'h000000};
        w1_next    = rk[95:64] ^ w0_next;
        w2_next    = rk[63:32] ^ w1_next;
        w3_next    = rk[31:0] ^ w2_next;
        rk_next    = {w0_next, w1_next, w2_next, w3_next};
        shifted    = shift_rows(sub_bytes);
        mixed      = mix_columns(shifted);
        last_round = (round_cnt == LAST_ROUND);
        round_out  = (last_round ? shifted : mixed) ^ rk_next;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        fsm_next  = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    fsm_next = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (last_round) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Datapath registers: load on accept, advance one round per ROUND cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= '0;
            rk        <= '0;
            round_cnt <= '0;
            rcon      <= '0;
        end else if (accept) begin
            state     <= plaintext ^ key;
            rk        <= key;
            round_cnt <= 4'd1;
            rcon      <= 8'h01;
        end else if (fsm == ROUND) begin
            state <= round_out;
            rk    <= rk_next;
            rcon  <= xtime(rcon);
            if (!last_round) begin
                round_cnt <= round_cnt + 4'd1;
            end
        end
    end

    assign ciphertext = state;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core against a behavioural FIPS-197 model.
module tb_aes128_encrypt_core;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_m  [256];
    logic [7:0]   isbox_m [256];
    logic [127:0] rks     [11];
    logic [7:0]   fwd_mix [4][4] = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
                                     '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
    logic [7:0]   inv_mix [4][4] = '{'{8'd14, 8'd11, 8'd13, 8'd9}, '{8'd9, 8'd14, 8'd11, 8'd13},
                                     '{8'd13, 8'd9, 8'd14, 8'd11}, '{8'd11, 8'd13, 8'd9, 8'd14}};

    logic [127:0] held_ct;
    logic [127:0] rnd_pt;
    logic [127:0] rnd_key;
    logic [127:0] exp_ct;
    logic [127:0] got_ct  [2];
    int           got_cyc [2];
    int           got;
    int           cyc;
    int           acc;
    int           lat;
    logic         taking;
    logic         stray_valid;

    aes128_encrypt_core #(.NR(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
        logic [15:0] d = {v, v};
        return d[15 - n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int unsigned x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int unsigned y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_m[x]  = s;
            isbox_m[s] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int unsigned i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int unsigned i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t ^= {rc, 24'h000000};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int unsigned r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int unsigned i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rks[0][127 - 8*i -: 8];
        for (int unsigned rnd = 1; rnd <= 10; rnd++) begin
            for (int unsigned c = 0; c < 4; c++)
                for (int unsigned r = 0; r < 4; r++)
                    t[r + 4*c] = sbox_m[s[r + 4*((c + r) % 4)]];
            for (int unsigned c = 0; c < 4; c++)
                for (int unsigned r = 0; r < 4; r++)
                    s[r + 4*c] = (rnd < 10) ? (gm(fwd_mix[r][0], t[4*c]) ^ gm(fwd_mix[r][1], t[4*c+1]) ^
                                               gm(fwd_mix[r][2], t[4*c+2]) ^ gm(fwd_mix[r][3], t[4*c+3]))
                                            : t[r + 4*c];
            for (int unsigned i = 0; i < 16; i++) s[i] ^= rks[rnd][127 - 8*i -: 8];
        end
        for (int unsigned i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        int unsigned  rnd;
        for (int unsigned i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ rks[10][127 - 8*i -: 8];
        for (int unsigned rr = 10; rr > 0; rr--) begin
            rnd = rr - 1;
            for (int unsigned c = 0; c < 4; c++)
                for (int unsigned r = 0; r < 4; r++)
                    t[r + 4*c] = isbox_m[s[r + 4*((c + 4 - r) % 4)]] ^ rks[rnd][127 - 8*(r + 4*c) -: 8];
            for (int unsigned c = 0; c < 4; c++)
                for (int unsigned r = 0; r < 4; r++)
                    s[r + 4*c] = (rnd > 0) ? (gm(inv_mix[r][0], t[4*c]) ^ gm(inv_mix[r][1], t[4*c+1]) ^
                                              gm(inv_mix[r][2], t[4*c+2]) ^ gm(inv_mix[r][3], t[4*c+3]))
                                           : t[r + 4*c];
        end
        for (int unsigned i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- bench helpers ----------------
    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] k);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_out(output int n, input bit scramble);
        n = 0;
        while (!out_valid && n < 40) begin
            if (scramble) begin
                plaintext = {$urandom, $urandom, $urandom, $urandom};
                key       = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            n++;
        end
        check("out_valid_arrives", out_valid, 1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;
        build_sbox();
        repeat (3) tick();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_ciphertext", ciphertext, '0);
        reset = 1'b0;
        tick();

        // FIPS-197 C.1 with latency measurement.
        send(PT_C1, KEY_C1);
        wait_out(lat, 1'b0);
        check("c1_latency", 128'(lat), 10);
        check("c1_ciphertext", ciphertext, CT_C1);

        // Backpressure: result held, new requests ignored.
        held_ct = ciphertext;
        for (int unsigned i = 0; i < 20; i++) begin
            in_valid  = i[0];
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check("bp_ct_stable", ciphertext, held_ct);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid_high", out_valid, 1);
        end
        in_valid = 1'b0;
        release_out();
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_busy", busy, 0);

        // FIPS-197 B with inputs scrambled every cycle after accept.
        send(PT_B, KEY_B);
        wait_out(lat, 1'b1);
        expand_key(KEY_B);
        check("b_ciphertext", ciphertext, CT_B);
        check("b_ciphertext_model", ciphertext, ref_encrypt(PT_B));
        check("b_rk10", dut.rk, RK10_B);
        check("b_rk10_model", dut.rk, rks[10]);
        release_out();

        // Reset in the middle of round 5 discards the block.
        send(PT_C1, KEY_C1);
        repeat (4) tick();
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_in_ready", in_ready, 1);
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_ciphertext", ciphertext, '0);
        check("mid_reset_rk", dut.rk, '0);
        stray_valid = 1'b0;
        repeat (12) begin
            tick();
            stray_valid |= out_valid;
        end
        check("mid_reset_no_output", stray_valid, 0);
        send(PT_C1, KEY_C1);
        wait_out(lat, 1'b0);
        check("post_reset_c1", ciphertext, CT_C1);
        release_out();

        // Random blocks against the model, with random downstream stalls.
        for (int unsigned n = 0; n < 4; n++) begin
            rnd_pt  = {$urandom, $urandom, $urandom, $urandom};
            rnd_key = {$urandom, $urandom, $urandom, $urandom};
            expand_key(rnd_key);
            exp_ct = ref_encrypt(rnd_pt);
            send(rnd_pt, rnd_key);
            wait_out(lat, 1'b0);
            check("rand_latency", 128'(lat), 10);
            check("rand_ciphertext", ciphertext, exp_ct);
            check("rand_roundtrip", ref_decrypt(ciphertext), rnd_pt);
            repeat ($urandom_range(0, 3)) tick();
            check("rand_ct_stable", ciphertext, exp_ct);
            release_out();
        end

        // Back-to-back: B then C.1 with out_ready held high.
        got = 0;
        cyc = 0;
        acc = 0;
        out_ready = 1'b1;
        plaintext = PT_B;
        key       = KEY_B;
        in_valid  = 1'b1;
        while (got < 2 && cyc < 80) begin
            taking = in_valid && in_ready;
            tick();
            cyc++;
            if (taking) begin
                acc++;
                if (acc == 1) begin
                    plaintext = PT_C1;
                    key       = KEY_C1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                got_ct[got]  = ciphertext;
                got_cyc[got] = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 128'(got), 2);
        check("b2b_first_ct", got_ct[0], CT_B);
        check("b2b_second_ct", got_ct[1], CT_C1);
        check("b2b_first_cycle", 128'(got_cyc[0]), 11);
        check("b2b_spacing", 128'(got_cyc[1] - got_cyc[0]), 12);
        expand_key(KEY_B);
        check("b2b_roundtrip_b", ref_decrypt(got_ct[0]), PT_B);
        expand_key(KEY_C1);
        check("b2b_roundtrip_c1", ref_decrypt(got_ct[1]), PT_C1);
        tick();
        out_ready = 1'b0;
        check("b2b_final_idle", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_encrypt_core.md
# aes128_encrypt_core

Iterative AES-128 encryption engine, FIPS-197 compliant, the forward-direction counterpart to the team's inverse-cipher (decrypt) datapath. It accepts one 128-bit plaintext block and one 128-bit cipher key per transaction and computes one cipher round per clock. Round keys are expanded on the fly, with no key RAM. It sits between the host-side block buffer and the ciphertext output FIFO, using valid/ready handshakes on both sides.

## Interface
- `NR`, default 10: number of rounds. Fixed to 10 for AES-128; there is no other legal value.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: plaintext and key are presented.
- `in_ready`, out, 1: core accepts a block. High only in IDLE.
- `plaintext`, in, 128: state byte i = `plaintext[127-8i -: 8]`, column-major (byte i is row i%4, column i/4).
- `key`, in, 128: cipher key, same byte order.
- `out_valid`, out, 1: ciphertext is valid and held stable until accepted.
- `out_ready`, in, 1: downstream accepts the ciphertext.
- `ciphertext`, out, 128: result, same byte order.
- `busy`, out, 1: high in ROUND or DONE.

## Operation
- FSM states and transitions:
  - IDLE → ROUND when `in_valid && in_ready`.
  - ROUND → DONE after the round-10 update.
  - DONE → IDLE when `out_valid && out_ready`.
- Accept edge (IDLE):
  - state ← plaintext ^ key (round-0 AddRoundKey).
  - rk ← key.
  - round counter ← 1.
  - rcon ← 0x01.
- Each ROUND edge, with r = round counter:
  - Next round key: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,0,0,0}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - State update for r < 10: state ← MixColumns(ShiftRows(SubBytes(state))) ^ rk'.
  - State update for r = 10: MixColumns is skipped.
  - rcon ← xtime(rcon). Sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - r ← r + 1. The counter is 4 bits and never exceeds 10.
- ShiftRows: row n rotates left by n bytes.
- MixColumns: per column, matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8) with polynomial 0x11b. Multiply-by-2 is xtime; multiply-by-3 is xtime(x)^x.
- All arithmetic is on 8-bit bytes. There are no carries between bytes.
- `ciphertext` is driven from the state register. It is valid only in DONE and is don't-care otherwise.
- `in_valid` while busy is ignored. Inputs are sampled only on the accept edge, so later input changes do not affect an in-flight block.
- Back-to-back blocks: ciphertext accepted in DONE gives IDLE on the next edge. A new block can be accepted on the following edge.

## Timing
- Reset (synchronous, any state, including mid-round or in DONE):
  - State goes to IDLE.
  - `in_ready` = 1, `out_valid` = 0, `busy` = 0.
  - `ciphertext`, state, rk, counter and rcon = 0.
  - An in-flight block is discarded with no output.
- Latency: accept at edge N gives `out_valid` = 1 after edge N+10. That is 10 ROUND cycles; DONE is entered on the round-10 edge.
- `out_valid` and `ciphertext` stay stable through DONE until `out_ready` is sampled high.
  - If `out_ready` is already high on the first DONE cycle, the transfer completes in that cycle and `out_valid` drops after the next edge.
- Throughput: at best one block per 12 cycles (accept, 10 rounds, 1 DONE cycle, plus the return to IDLE).
- `in_ready` and `out_valid` are never high in the same cycle.

## Structure
- Package `aes_pkg` holds:
  - `NR`.
  - Typedefs: `aes_byte_t` (8b), `aes_word_t` (32b), `aes_block_t` (128b).
  - FSM enum: IDLE, ROUND, DONE.
  - Functions `xtime`, `gmul2`, `gmul3`, `shift_rows`, `mix_columns`.
- Sub-module `aes_sbox_fwd`: combinational forward S-box, 8b in and 8b out, as a case-table ROM. Instantiate 20 copies: 16 for SubBytes and 4 for SubWord.
- The top level contains the FSM, the state, rk, counter and rcon registers, the key-schedule XOR chain, and the handshake logic.

## Test plan
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` exactly 10 edges after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32. Also check the internal rk after round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold `out_ready` = 0 for 20 cycles after the App. C.1 result → `ciphertext` stays stable, `in_valid` pulses are ignored, and `in_ready` = 0 throughout.
- Input change mid-block: toggle `plaintext` and `key` every cycle after accept → the App. B result is unchanged.
- Reset at round 5 → next cycle IDLE with all outputs zero. A fresh App. C.1 block then completes correctly.
- Back-to-back: `out_ready` and `in_valid` held at 1 with App. B followed by App. C.1 → both results arrive in order, 12 cycles apart. The sequence is then cross-checked round-trip through the decrypt datapath to recover the plaintexts.
